// File: rtl/fp_to_twoscomp_if.sv
// Handshake bundle for the float-to-two's-complement decoder.
// master: the producer/consumer side (bench or surrounding datapath).
// slave: the decoder itself.
interface fp_to_twoscomp_if #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 13
);
    logic             in_valid;
    logic             in_ready;
    logic             s_in;
    logic [EXP_W-1:0] e_in;
    logic [SIG_W-1:0] f_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] dout;
    logic             ovf;

    modport master (
        output in_valid, s_in, e_in, f_in, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, s_in, e_in, f_in, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/fp_to_twoscomp.sv
// Decodes a compact float word {S, E, F} (value = (-1)^S * F * 2^E) into an
// OUT_W-bit two's-complement result. The magnitude is shifted left one bit
// per cycle, then negated when the sign is set.
// Optional feature macro: FP2TC_SAT_EN -- when defined, out-of-range results
// clamp to the most positive / most negative code and raise ovf; otherwise
// the result wraps to the low OUT_W bits and ovf stays 0.
module fp_to_twoscomp #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    fp_to_twoscomp_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, NEGATE, DONE} state_t;

    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [OUT_W-1:0] mag;
    logic [EXP_W-1:0] cnt;
    logic             sgn;
    logic [OUT_W-1:0] dout_r;
    logic             accept;

    // Wrapping conversion: two's-complement negate, with -0 folded to 0.
    function automatic logic [OUT_W-1:0] wrap_fn(input logic s,
                                                 input logic [OUT_W-1:0] m);
        if (s && (m != '0))
            return (~m) + ONE;
        return m;
    endfunction

`ifdef FP2TC_SAT_EN
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic ovf_acc;
    logic ovf_r;

    // Saturating conversion: returns {ovf, dout}. A negative magnitude of
    // exactly 2^(OUT_W-1) is still representable, so it does not clamp.
    function automatic logic [OUT_W:0] sat_fn(input logic s,
                                              input logic [OUT_W-1:0] m,
                                              input logic acc);
        if (s) begin
            if (acc || (m > NEG_MIN))
                return {1'b1, NEG_MIN};
        end else begin
            if (acc || (m > POS_MAX))
                return {1'b1, POS_MAX};
        end
        return {1'b0, wrap_fn(s, m)};
    endfunction

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

    assign accept   = bus.in_valid && bus.in_ready;
    assign bus.dout = dout_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = NEGATE;
            NEGATE:  state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; in_ready drops immediately while reset is held.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        if ((state == IDLE) && !rst)
            bus.in_ready = 1'b1;
        if (state == DONE)
            bus.out_valid = 1'b1;
    end

    // Datapath: capture on accept, shift one bit per cycle, then resolve sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag     <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            dout_r  <= '0;
`ifdef FP2TC_SAT_EN
            ovf_acc <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag     <= OUT_W'(bus.f_in);
                        cnt     <= bus.e_in;
                        sgn     <= bus.s_in;
`ifdef FP2TC_SAT_EN
                        ovf_acc <= 1'b0;
                        ovf_r   <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - EXP_W'(1);
`ifdef FP2TC_SAT_EN
                        // Bit leaving the register, or a bit landing in the sign position.
                        if (mag[OUT_W-1] || mag[OUT_W-2])
                            ovf_acc <= 1'b1;
`endif
                    end
                end
                NEGATE: begin
`ifdef FP2TC_SAT_EN
                    {ovf_r, dout_r} <= sat_fn(sgn, mag, ovf_acc);
`else
                    dout_r <= wrap_fn(sgn, mag);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_twoscomp.sv
// Directed bench for fp_to_twoscomp: a default 13-bit instance and an 8-bit
// instance (exercising FP2TC_SAT_EN when that macro is defined).
module tb_fp_to_twoscomp;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    fp_to_twoscomp_if #(.EXP_W(3), .SIG_W(4), .OUT_W(13)) bus13 ();
    fp_to_twoscomp_if #(.EXP_W(3), .SIG_W(4), .OUT_W(8))  bus8  ();

    fp_to_twoscomp #(.EXP_W(3), .SIG_W(4), .OUT_W(13)) dut13 (
        .clk (clk),
        .rst (rst),
        .bus (bus13)
    );

    fp_to_twoscomp #(.EXP_W(3), .SIG_W(4), .OUT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word to the 13-bit instance and wait for its result.
    task automatic convert13(input logic s, input logic [2:0] e, input logic [3:0] f,
                             input bit consume, output int lat,
                             output logic [12:0] d, output logic ov);
        int k;
        lat = -1;
        d   = 'x;
        ov  = 1'bx;
        k   = 0;
        while (!bus13.in_ready && k < 30) begin
            tick();
            k++;
        end
        bus13.s_in     = s;
        bus13.e_in     = e;
        bus13.f_in     = f;
        bus13.in_valid = 1'b1;
        tick();
        bus13.in_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus13.out_valid) begin
                lat = i;
                break;
            end
        end
        d  = bus13.dout;
        ov = bus13.ovf;
        if (consume && lat > 0) begin
            bus13.out_ready = 1'b1;
            tick();
            bus13.out_ready = 1'b0;
        end
    endtask

    // Present one word to the 8-bit instance and consume its result.
    task automatic convert8(input logic s, input logic [2:0] e, input logic [3:0] f,
                            output int lat, output logic [7:0] d, output logic ov);
        int k;
        lat = -1;
        d   = 'x;
        ov  = 1'bx;
        k   = 0;
        while (!bus8.in_ready && k < 30) begin
            tick();
            k++;
        end
        bus8.s_in     = s;
        bus8.e_in     = e;
        bus8.f_in     = f;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus8.out_valid) begin
                lat = i;
                break;
            end
        end
        d  = bus8.dout;
        ov = bus8.ovf;
        if (lat > 0) begin
            bus8.out_ready = 1'b1;
            tick();
            bus8.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus13.in_valid = 1'b0; bus13.out_ready = 1'b0;
        bus13.s_in = 1'b0; bus13.e_in = '0; bus13.f_in = '0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.s_in = 1'b0; bus8.e_in = '0; bus8.f_in = '0;
        tick();
        tick();
        total++; if (bus13.in_ready !== 1'b0) $display("FAIL rst_in_ready13: got %b expected 0", bus13.in_ready); else passed++;
        total++; if (bus13.out_valid !== 1'b0) $display("FAIL rst_out_valid13: got %b expected 0", bus13.out_valid); else passed++;
        total++; if (bus13.dout !== 13'd0) $display("FAIL rst_dout13: got %h expected 0", bus13.dout); else passed++;
        total++; if (bus13.ovf !== 1'b0) $display("FAIL rst_ovf13: got %b expected 0", bus13.ovf); else passed++;
        total++; if (bus8.in_ready !== 1'b0) $display("FAIL rst_in_ready8: got %b expected 0", bus8.in_ready); else passed++;
        total++; if (bus8.out_valid !== 1'b0) $display("FAIL rst_out_valid8: got %b expected 0", bus8.out_valid); else passed++;
        total++; if (bus8.dout !== 8'd0) $display("FAIL rst_dout8: got %h expected 0", bus8.dout); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus13.in_ready !== 1'b1) $display("FAIL rel_in_ready13: got %b expected 1", bus13.in_ready); else passed++;
        total++; if (bus8.in_ready !== 1'b1) $display("FAIL rel_in_ready8: got %b expected 1", bus8.in_ready); else passed++;
        tick();
    endtask

    task automatic test_max_positive();
        int lat; logic [12:0] d; logic ov;
        convert13(1'b0, 3'd7, 4'hF, 1'b1, lat, d, ov);
        total++; if (lat != 9) $display("FAIL pos_max_latency: got %0d expected 9", lat); else passed++;
        total++; if (d !== 13'd1920) $display("FAIL pos_max_dout: got %0d expected 1920", d); else passed++;
        total++; if (ov !== 1'b0) $display("FAIL pos_max_ovf: got %b expected 0", ov); else passed++;
    endtask

    task automatic test_negative();
        int lat; logic [12:0] d; logic ov;
        convert13(1'b1, 3'd7, 4'hF, 1'b1, lat, d, ov);
        total++; if (lat != 9) $display("FAIL neg_max_latency: got %0d expected 9", lat); else passed++;
        total++; if (d !== 13'h1880) $display("FAIL neg_max_dout: got %h expected 1880", d); else passed++;
        convert13(1'b1, 3'd0, 4'h1, 1'b1, lat, d, ov);
        total++; if (lat != 2) $display("FAIL neg_one_latency: got %0d expected 2", lat); else passed++;
        total++; if (d !== 13'h1FFF) $display("FAIL neg_one_dout: got %h expected 1fff", d); else passed++;
        convert13(1'b1, 3'd0, 4'h0, 1'b1, lat, d, ov);
        total++; if (d !== 13'd0) $display("FAIL neg_zero_dout: got %h expected 0", d); else passed++;
    endtask

    task automatic test_backpressure();
        int lat; logic [12:0] d; logic ov;
        convert13(1'b0, 3'd3, 4'h5, 1'b0, lat, d, ov);
        total++; if (lat != 5) $display("FAIL bp_latency: got %0d expected 5", lat); else passed++;
        total++; if (d !== 13'd40) $display("FAIL bp_dout: got %0d expected 40", d); else passed++;
        bus13.s_in = 1'b0; bus13.e_in = 3'd0; bus13.f_in = 4'h1;
        bus13.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus13.out_valid !== 1'b1) $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", i, bus13.out_valid); else passed++;
            total++; if (bus13.dout !== 13'd40) $display("FAIL bp_hold_dout: cycle %0d got %0d expected 40", i, bus13.dout); else passed++;
            total++; if (bus13.in_ready !== 1'b0) $display("FAIL bp_hold_in_ready: cycle %0d got %b expected 0", i, bus13.in_ready); else passed++;
        end
        bus13.out_ready = 1'b1;
        tick();
        bus13.out_ready = 1'b0;
        total++; if (bus13.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", bus13.in_ready); else passed++;
        tick();
        bus13.in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus13.out_valid) begin
                lat = i;
                break;
            end
        end
        total++; if (lat != 2) $display("FAIL bp_next_latency: got %0d expected 2", lat); else passed++;
        total++; if (bus13.dout !== 13'd1) $display("FAIL bp_next_dout: got %0d expected 1", bus13.dout); else passed++;
        bus13.out_ready = 1'b1;
        tick();
        bus13.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int lat; int seen; logic [12:0] d; logic ov;
        bus13.s_in = 1'b0; bus13.e_in = 3'd7; bus13.f_in = 4'hF;
        bus13.in_valid = 1'b1;
        tick();
        bus13.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        total++; if (bus13.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b expected 0", bus13.out_valid); else passed++;
        total++; if (bus13.dout !== 13'd0) $display("FAIL mid_rst_dout: got %h expected 0", bus13.dout); else passed++;
        total++; if (bus13.in_ready !== 1'b0) $display("FAIL mid_rst_in_ready: got %b expected 0", bus13.in_ready); else passed++;
        tick(); tick();
        total++; if (bus13.in_ready !== 1'b0) $display("FAIL mid_rst_held_in_ready: got %b expected 0", bus13.in_ready); else passed++;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus13.out_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL mid_rst_no_result: got %0d results expected 0", seen); else passed++;
        convert13(1'b0, 3'd1, 4'h3, 1'b1, lat, d, ov);
        total++; if (lat != 3) $display("FAIL post_rst_latency: got %0d expected 3", lat); else passed++;
        total++; if (d !== 13'd6) $display("FAIL post_rst_dout: got %0d expected 6", d); else passed++;
    endtask

    task automatic test_back_to_back();
        int nacc; int nres; logic acc;
        logic [12:0] r0; logic [12:0] r1;
        nacc = 0; nres = 0; r0 = 'x; r1 = 'x;
        bus13.out_ready = 1'b1;
        bus13.s_in = 1'b0; bus13.e_in = 3'd0; bus13.f_in = 4'h5;
        bus13.in_valid = 1'b1;
        for (int i = 0; i < 40 && nres < 2; i++) begin
            acc = bus13.in_valid && bus13.in_ready;
            tick();
            if (acc) begin
                nacc++;
                if (nacc == 1) bus13.e_in = 3'd2;
                else bus13.in_valid = 1'b0;
            end
            if (bus13.out_valid) begin
                if (nres == 0) r0 = bus13.dout;
                else r1 = bus13.dout;
                nres++;
            end
        end
        bus13.in_valid = 1'b0;
        tick();
        bus13.out_ready = 1'b0;
        total++; if (nacc != 2) $display("FAIL b2b_accepts: got %0d expected 2", nacc); else passed++;
        total++; if (nres != 2) $display("FAIL b2b_results: got %0d expected 2", nres); else passed++;
        total++; if (r0 !== 13'd5) $display("FAIL b2b_first_dout: got %0d expected 5", r0); else passed++;
        total++; if (r1 !== 13'd20) $display("FAIL b2b_second_dout: got %0d expected 20", r1); else passed++;
    endtask

    task automatic test_narrow_output();
        int lat; logic [7:0] d; logic ov;
        logic [7:0] exp_pos; logic exp_ovf;
`ifdef FP2TC_SAT_EN
        exp_pos = 8'h7F; exp_ovf = 1'b1;
`else
        exp_pos = 8'h80; exp_ovf = 1'b0;
`endif
        convert8(1'b0, 3'd7, 4'hF, lat, d, ov);
        total++; if (lat != 9) $display("FAIL w8_pos_latency: got %0d expected 9", lat); else passed++;
        total++; if (d !== exp_pos) $display("FAIL w8_pos_dout: got %h expected %h", d, exp_pos); else passed++;
        total++; if (ov !== exp_ovf) $display("FAIL w8_pos_ovf: got %b expected %b", ov, exp_ovf); else passed++;
        convert8(1'b1, 3'd7, 4'hF, lat, d, ov);
        total++; if (d !== 8'h80) $display("FAIL w8_neg_dout: got %h expected 80", d); else passed++;
        total++; if (ov !== exp_ovf) $display("FAIL w8_neg_ovf: got %b expected %b", ov, exp_ovf); else passed++;
        convert8(1'b0, 3'd2, 4'h3, lat, d, ov);
        total++; if (d !== 8'd12) $display("FAIL w8_small_dout: got %0d expected 12", d); else passed++;
        total++; if (ov !== 1'b0) $display("FAIL w8_small_ovf: got %b expected 0", ov); else passed++;
    endtask

    initial begin
        test_reset();
        test_max_positive();
        test_negative();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_narrow_output();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end

endmodule
